// File: rtl/branch_sequencer.sv
// Program-counter sequencer: owns the PC, the fetch handshake and taken-branch redirect.
// Optional CALL/RET with a single-entry link register when CALL_LINK_EN is defined.
module branch_sequencer #(
    parameter int            AW       = 8,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [4:0]    Opcode,
    input  logic          ir_valid,
    input  logic [AW-1:0] target,
    input  logic          jmp,
    input  logic          stall,
    input  logic          fetch_ack,
    output logic [AW-1:0] pc,
    output logic          fetch_req,
    output logic          flush,
    output logic          br_busy
);

    typedef enum logic [1:0] {IDLE, FETCH, EXEC, RESOLVE} state_t;

    state_t        state;
    logic [AW-1:0] target_q;
    logic [AW-1:0] pc_inc;
    logic          is_branch;
    logic          exec_go;

    assign pc_inc    = pc + AW'(1);
    assign is_branch = (Opcode >= 5'b01011) && (Opcode <= 5'b10001);
    assign exec_go   = (state == EXEC) && ir_valid;

`ifdef CALL_LINK_EN
    logic [AW-1:0] link;
    logic          is_call;
    logic          is_ret;

    assign is_call = (Opcode == 5'b10010);
    assign is_ret  = (Opcode == 5'b10011);
`endif

    always_comb begin
        fetch_req = (state == FETCH) && !stall;
        br_busy   = (state == RESOLVE);
        flush     = !stall && (state == RESOLVE) && jmp;
`ifdef CALL_LINK_EN
        // CALL/RET redirect straight out of EXEC, so they flush there too
        if (!stall && exec_go && (is_call || is_ret))
            flush = 1'b1;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            target_q <= '0;
`ifdef CALL_LINK_EN
            link     <= '0;
`endif
        end else if (!stall) begin
            case (state)
                IDLE: state <= FETCH;
                FETCH: begin
                    if (fetch_ack)
                        state <= EXEC;
                end
                EXEC: begin
                    if (ir_valid) begin
`ifdef CALL_LINK_EN
                        if (is_call) begin
                            link  <= pc_inc;
                            pc    <= target;
                            state <= FETCH;
                        end else if (is_ret) begin
                            pc    <= link;
                            state <= FETCH;
                        end else
`endif
                        if (is_branch) begin
                            target_q <= target;
                            state    <= RESOLVE;
                        end else begin
                            pc    <= pc_inc;
                            state <= FETCH;
                        end
                    end
                end
                RESOLVE: begin
                    // jmp arrives registered, one edge after the branch opcode was seen in EXEC
                    pc    <= jmp ? target_q : pc_inc;
                    state <= FETCH;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed table-driven bench for branch_sequencer, plus a reset-during-RESOLVE sequence.
// Expectations follow CALL_LINK_EN when the bench is compiled with that macro.
module tb_branch_sequencer;

    localparam int AW = 8;
`ifdef CALL_LINK_EN
    localparam bit CL = 1'b1;
`else
    localparam bit CL = 1'b0;
`endif

    localparam logic [4:0] NB   = 5'b00001;
    localparam logic [4:0] BR   = 5'b01011;
    localparam logic [4:0] UNC  = 5'b10001;
    localparam logic [4:0] CALL = 5'b10010;
    localparam logic [4:0] RET  = 5'b10011;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [4:0]    Opcode;
    logic          ir_valid;
    logic [AW-1:0] target;
    logic          jmp;
    logic          stall;
    logic          fetch_ack;
    logic [AW-1:0] pc;
    logic          fetch_req;
    logic          flush;
    logic          br_busy;

    typedef struct {
        logic          st;
        logic          iv;
        logic [4:0]    op;
        logic [AW-1:0] tg;
        logic          j;
        logic          ack;
        logic [AW-1:0] e_pc;
        logic          e_fr;
        logic          e_fl;
        logic          e_bb;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    branch_sequencer #(.AW(AW), .RESET_PC(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .ir_valid(ir_valid),
        .target(target), .jmp(jmp), .stall(stall), .fetch_ack(fetch_ack),
        .pc(pc), .fetch_req(fetch_req), .flush(flush), .br_busy(br_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic st, input logic iv, input logic [4:0] op, input logic [AW-1:0] tg,
                       input logic j, input logic ack, input logic [AW-1:0] e_pc,
                       input logic e_fr, input logic e_fl, input logic e_bb);
        vec_t v;
        v.st = st; v.iv = iv; v.op = op; v.tg = tg; v.j = j; v.ack = ack;
        v.e_pc = e_pc; v.e_fr = e_fr; v.e_fl = e_fl; v.e_bb = e_bb;
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        stall = v.st; ir_valid = v.iv; Opcode = v.op; target = v.tg; jmp = v.j; fetch_ack = v.ack;
    endtask

    initial begin
        logic [AW-1:0] p_call;
        p_call = CL ? 8'h80 : 8'h11;

        // st iv op tg j ack | pc fr fl bb
        add(0, 0, NB,   8'h00, 0, 1, 8'h00, 0, 0, 0); // IDLE
        add(0, 0, NB,   8'h00, 0, 1, 8'h00, 1, 0, 0); // FETCH
        add(0, 1, NB,   8'h00, 0, 1, 8'h00, 0, 0, 0); // EXEC -> pc 1
        add(0, 0, NB,   8'h00, 0, 1, 8'h01, 1, 0, 0);
        add(0, 0, NB,   8'h00, 0, 1, 8'h01, 0, 0, 0); // EXEC, ir_valid=0 holds
        add(0, 1, NB,   8'h00, 0, 1, 8'h01, 0, 0, 0); // -> pc 2
        add(0, 0, NB,   8'h00, 0, 0, 8'h02, 1, 0, 0); // FETCH, no ack
        add(1, 0, NB,   8'h00, 0, 1, 8'h02, 0, 0, 0); // FETCH stalled
        add(0, 0, NB,   8'h00, 0, 1, 8'h02, 1, 0, 0);
        add(0, 1, NB,   8'h00, 0, 1, 8'h02, 0, 0, 0); // -> 3
        add(0, 0, NB,   8'h00, 0, 1, 8'h03, 1, 0, 0);
        add(0, 1, NB,   8'h00, 0, 1, 8'h03, 0, 0, 0); // -> 4
        add(0, 0, NB,   8'h00, 0, 1, 8'h04, 1, 0, 0);
        add(0, 1, NB,   8'h00, 0, 1, 8'h04, 0, 0, 0); // -> 5
        add(0, 0, NB,   8'h00, 0, 1, 8'h05, 1, 0, 0);
        add(0, 1, BR,   8'h40, 0, 1, 8'h05, 0, 0, 0); // EXEC branch
        add(0, 0, BR,   8'h40, 1, 1, 8'h05, 0, 1, 1); // RESOLVE taken
        add(0, 0, NB,   8'h00, 0, 1, 8'h40, 1, 0, 0);
        add(0, 1, BR,   8'h10, 0, 1, 8'h40, 0, 0, 0);
        add(0, 0, BR,   8'h10, 0, 1, 8'h40, 0, 0, 1); // RESOLVE not taken
        add(0, 0, NB,   8'h00, 0, 1, 8'h41, 1, 0, 0);
        add(0, 1, UNC,  8'hFF, 0, 1, 8'h41, 0, 0, 0);
        add(0, 0, UNC,  8'hFF, 1, 1, 8'h41, 0, 1, 1);
        add(0, 0, NB,   8'h00, 0, 1, 8'hFF, 1, 0, 0);
        add(0, 1, NB,   8'h00, 0, 1, 8'hFF, 0, 0, 0); // wrap FF -> 00
        add(0, 0, NB,   8'h00, 0, 1, 8'h00, 1, 0, 0);
        add(0, 1, BR,   8'h20, 0, 1, 8'h00, 0, 0, 0);
        add(1, 0, BR,   8'h20, 1, 1, 8'h00, 0, 0, 1); // RESOLVE stalled x3
        add(1, 0, BR,   8'h20, 1, 1, 8'h00, 0, 0, 1);
        add(1, 0, BR,   8'h20, 1, 1, 8'h00, 0, 0, 1);
        add(0, 0, BR,   8'h20, 1, 1, 8'h00, 0, 1, 1); // first unstalled cycle
        add(0, 0, NB,   8'h00, 0, 1, 8'h20, 1, 0, 0);
        add(0, 1, BR,   8'h10, 0, 1, 8'h20, 0, 0, 0);
        add(0, 0, BR,   8'h10, 1, 1, 8'h20, 0, 1, 1);
        add(0, 0, NB,   8'h00, 0, 1, 8'h10, 1, 0, 0);
        add(0, 1, CALL, 8'h80, 0, 1, 8'h10, 0, CL, 0);
        add(0, 0, NB,   8'h00, 0, 1, p_call, 1, 0, 0);
        add(0, 1, NB,   8'h00, 0, 1, p_call, 0, 0, 0);
        add(0, 0, NB,   8'h00, 0, 1, p_call + 8'h01, 1, 0, 0);
        add(0, 1, RET,  8'h00, 0, 1, p_call + 8'h01, 0, CL, 0);
        add(0, 0, NB,   8'h00, 0, 1, CL ? 8'h11 : 8'h13, 1, 0, 0);

        rst_n = 1'b0;
        drive(vecs[0]);
        repeat (2) @(negedge clk);
        #1;
        check("reset_pc", pc, 8'h00);
        check("reset_fetch_req", fetch_req, 0);
        check("reset_flush", flush, 0);
        check("reset_br_busy", br_busy, 0);

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            if (i != 0) @(negedge clk);
            drive(vecs[i]);
            #1;
            check($sformatf("row%0d_pc", i), pc, vecs[i].e_pc);
            check($sformatf("row%0d_fetch_req", i), fetch_req, vecs[i].e_fr);
            check($sformatf("row%0d_flush", i), flush, vecs[i].e_fl);
            check($sformatf("row%0d_br_busy", i), br_busy, vecs[i].e_bb);
        end

        // Reset pulsed while a taken branch sits in RESOLVE
        @(negedge clk);
        stall = 0; ir_valid = 1; Opcode = BR; target = 8'h55; jmp = 0; fetch_ack = 1;
        @(negedge clk);
        jmp = 1; ir_valid = 0;
        #1;
        check("rst_mid_pre_busy", br_busy, 1);
        check("rst_mid_pre_flush", flush, 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_pc", pc, 8'h00);
        check("rst_mid_busy", br_busy, 0);
        check("rst_mid_flush", flush, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_after_idle_fr", fetch_req, 0);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_after%0d_flush", k), flush, 0);
            check($sformatf("rst_after%0d_pc", k), pc, 8'h00);
            check($sformatf("rst_after%0d_busy", k), br_busy, 0);
            fetch_ack = 0;
            @(negedge clk);
            #1;
        end
        check("rst_after_fetch_fr", fetch_req, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule
